// File: rtl/sof_scheduler_if.sv
// Bus bundle between the SOF scheduler (slave) and its surroundings (master).
// The SOFTimeout strobe exists only when SOF_SCHED_TIMEOUT_EN is defined.
interface sof_scheduler_if;
  logic        SOFEnable;
  logic        SOFTxGnt;
  logic        sendPacketRdy;
  logic        SOFTxReq;
  logic        SOF_SP_WEn;
  logic [10:0] frameNum;
  logic [15:0] SOFTimer;
  logic        SOFGuard;
  logic        SOFSent;
  logic        SOFOverrun;
`ifdef SOF_SCHED_TIMEOUT_EN
  logic        SOFTimeout;
`endif

  modport slave (
    input  SOFEnable, SOFTxGnt, sendPacketRdy,
`ifdef SOF_SCHED_TIMEOUT_EN
    output SOFTimeout,
`endif
    output SOFTxReq, SOF_SP_WEn, frameNum, SOFTimer, SOFGuard, SOFSent, SOFOverrun
  );

  modport master (
    output SOFEnable, SOFTxGnt, sendPacketRdy,
`ifdef SOF_SCHED_TIMEOUT_EN
    input  SOFTimeout,
`endif
    input  SOFTxReq, SOF_SP_WEn, frameNum, SOFTimer, SOFGuard, SOFSent, SOFOverrun
  );
endinterface

// File: rtl/sof_scheduler.sv
// USB start-of-frame scheduler: frame countdown, frame numbering and the SOF send handshake.
// Define SOF_SCHED_TIMEOUT_EN to add a 255-cycle abort on stalled handshakes (SOFTimeout strobe).
module sof_scheduler #(
  parameter logic [15:0] FRAME_PERIOD = 16'd48000,
  parameter logic [15:0] GUARD_TIME   = 16'd1200
) (
  input  logic           clk,
  input  logic           rst,
  sof_scheduler_if.slave bus,
  output logic [2:0]     dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_WEN       = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_e;

  state_e      state_q;
  logic [15:0] timer_q, timer_d;
  logic [10:0] frame_q, frame_d;
  logic        frame_start;
  logic        req_q, wen_q, sent_q, ovr_q;

  // A frame starts whenever the enabled countdown sits at zero, including the first enabled cycle.
  always_comb begin
    frame_start = bus.SOFEnable && (timer_q == 16'd0);
    timer_d     = timer_q;
    frame_d     = frame_q;
    if (!bus.SOFEnable) begin
      timer_d = 16'd0;
    end else if (frame_start) begin
      timer_d = FRAME_PERIOD - 16'd1;
      frame_d = frame_q + 11'd1;
    end else begin
      timer_d = timer_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= 16'd0;
      frame_q <= 11'd0;
    end else begin
      timer_q <= timer_d;
      frame_q <= frame_d;
    end
  end

`ifdef SOF_SCHED_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       to_q;
  logic       waiting, advance;

  always_comb begin
    waiting = (state_q == S_REQ) || (state_q == S_WAIT_RDY) ||
              (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
    advance = ((state_q == S_REQ)       &&  bus.SOFTxGnt)     ||
              ((state_q == S_WAIT_RDY)  &&  bus.sendPacketRdy) ||
              ((state_q == S_WAIT_BUSY) && !bus.sendPacketRdy) ||
              ((state_q == S_WAIT_DONE) &&  bus.sendPacketRdy);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      sent_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SOF_SCHED_TIMEOUT_EN
      to_cnt_q <= 8'd0;
      to_q     <= 1'b0;
`endif
    end else begin
      sent_q <= 1'b0;
      ovr_q  <= (frame_start && (state_q != S_IDLE));
      case (state_q)
        S_IDLE: if (frame_start) begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: if (bus.SOFTxGnt) state_q <= S_WAIT_RDY;
        S_WAIT_RDY: if (bus.sendPacketRdy) begin
          state_q <= S_WEN;
          wen_q   <= 1'b1;
        end
        S_WEN: begin
          state_q <= S_WAIT_BUSY;
          wen_q   <= 1'b0;
        end
        S_WAIT_BUSY: if (!bus.sendPacketRdy) state_q <= S_WAIT_DONE;
        // A frame start coinciding with completion is reported as overrun and not re-requested.
        S_WAIT_DONE: if (bus.sendPacketRdy) begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          sent_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          wen_q   <= 1'b0;
        end
      endcase
`ifdef SOF_SCHED_TIMEOUT_EN
      // Counter restarts on every entry into a wait state; the abort overrides the case above.
      to_q <= 1'b0;
      if (!waiting || advance) begin
        to_cnt_q <= 8'd0;
      end else if (to_cnt_q == 8'd254) begin
        to_cnt_q <= 8'd0;
        state_q  <= S_IDLE;
        req_q    <= 1'b0;
        wen_q    <= 1'b0;
        to_q     <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
`endif
    end
  end

  assign bus.SOFTxReq   = req_q;
  assign bus.SOF_SP_WEn = wen_q;
  assign bus.SOFSent    = sent_q;
  assign bus.SOFOverrun = ovr_q;
  assign bus.frameNum   = frame_q;
  assign bus.SOFTimer   = timer_q;
  assign bus.SOFGuard   = bus.SOFEnable && (timer_q < GUARD_TIME);
`ifdef SOF_SCHED_TIMEOUT_EN
  assign bus.SOFTimeout = to_q;
`endif
  assign dbg_state_o    = state_q;

endmodule

// File: doc/sof_scheduler.md
SOF_SCHEDULER -- requirements
Module: sof_scheduler

Interface
REQ-001 Parameter FRAME_PERIOD, 16'd48000, clocks per USB frame (1 ms at 48 MHz); legal range 16..65535.
REQ-002 Parameter GUARD_TIME, 16'd1200, clocks before frame end during which new host transactions are blocked; shall be < FRAME_PERIOD.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 SOFEnable  input  1  level; 1 = generate SOF packets.
REQ-006 SOFTxGnt  input  1  grant from send-packet arbiter.
REQ-007 sendPacketRdy  input  1  1 = packet sender idle and able to accept a packet.
REQ-008 SOFTxReq  output  1  request to send-packet arbiter.
REQ-009 SOF_SP_WEn  output  1  one-cycle write strobe to packet sender.
REQ-010 frameNum  output  11  current frame number, SOF token payload.
REQ-011 SOFTimer  output  16  frame countdown value.
REQ-012 SOFGuard  output  1  1 = frame end near; host transaction scheduler shall not start a transaction.
REQ-013 SOFSent  output  1  one-cycle pulse, SOF packet completed.
REQ-014 SOFOverrun  output  1  one-cycle pulse, frame start while previous SOF still pending.

Function
REQ-015 Timer: SOFEnable=0 -> SOFTimer<=0; SOFEnable=1 and SOFTimer=0 -> frame-start event; SOFEnable=1 and SOFTimer>0 -> SOFTimer decrements by 1.
REQ-016 Frame-start event: SOFTimer<=FRAME_PERIOD-1, frameNum<=frameNum+1 modulo 2048 (2047 wraps to 0).
REQ-017 First SOF: SOFEnable rising sampled at edge k (timer=0) -> frame-start at edge k; SOFTxReq=1 after edge k.
REQ-018 SOFGuard = SOFEnable & (SOFTimer < GUARD_TIME), combinational.
REQ-019 FSM states IDLE, REQ, WAIT_RDY, WEN, WAIT_BUSY, WAIT_DONE; all outputs registered except SOFGuard.
REQ-020 IDLE: frame-start -> REQ, SOFTxReq<=1.
REQ-021 REQ: SOFTxGnt=1 -> WAIT_RDY.
REQ-022 WAIT_RDY: sendPacketRdy=1 -> WEN, SOF_SP_WEn<=1 (exactly one cycle).
REQ-023 WEN: unconditional -> WAIT_BUSY, SOF_SP_WEn<=0.
REQ-024 WAIT_BUSY: sendPacketRdy=0 -> WAIT_DONE.
REQ-025 WAIT_DONE: sendPacketRdy=1 -> IDLE, SOFTxReq<=0, SOFSent<=1 for one cycle.
REQ-026 Frame-start while not IDLE: SOFOverrun pulses one cycle; no second request queued; timer and frameNum still update.
REQ-027 Frame-start in same cycle as WAIT_DONE completion: completion taken (->IDLE), SOFOverrun pulses, new request not issued until next frame.
REQ-028 SOFEnable dropped mid-transaction: current transaction completes normally; no further requests.
REQ-029 SOFTxReq held continuously from REQ through WAIT_DONE; never dropped before SOFSent.

Reset
REQ-030 rst=0 asynchronously forces: state IDLE, SOFTimer=0, frameNum=0, SOFTxReq=0, SOF_SP_WEn=0, SOFSent=0, SOFOverrun=0, timeout counter=0.
REQ-031 Reset mid-transaction abandons it; no SOFSent issued.

Configuration
REQ-032 Macro SOF_SCHED_TIMEOUT_EN defined: 8-bit counter cleared on entry to REQ/WAIT_RDY/WAIT_BUSY/WAIT_DONE, increments each cycle in those states; reaching 255 -> IDLE, SOFTxReq<=0, SOF_SP_WEn<=0, extra output SOFTimeout pulses one cycle, no SOFSent.
REQ-033 Macro undefined: no counter, no SOFTimeout port; FSM waits indefinitely.

Verification (FRAME_PERIOD=100, GUARD_TIME=10)
REQ-034 Enable at edge k, grant next cycle, Rdy=1, Rdy low 3 cycles after WEn -> SOFTxReq at k, one WEn pulse, SOFSent once, frameNum=1.
REQ-035 Enable 3 frames, immediate grant/ready -> frame-starts spaced exactly 100 cycles; frameNum 1,2,3; SOFGuard high exactly 10 cycles per frame (SOFTimer 9..0).
REQ-036 Preload 2046 frames -> frameNum 2047 then 0; no overrun.
REQ-037 Withhold SOFTxGnt 150 cycles -> SOFOverrun one pulse at 2nd frame-start; single SOFSent after grant.
REQ-038 rst=0 during WAIT_DONE -> all outputs zero immediately, not clock-dependent; no SOFSent.
REQ-039 SOF_SCHED_TIMEOUT_EN, sendPacketRdy stuck 0 -> SOFTimeout pulse 255 cycles after WAIT_RDY entry; SOFTxReq=0; next frame requests again.
